// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two requester FIFOs drained round-robin into the register file write port.
// Optional combinational forwarding lookup is enabled by defining WB_FORWARD_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          regWrite,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          busy
`ifdef WB_FORWARD_EN
  ,
  input  logic [AW-1:0] fwd_reg,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Index 0 is requester A, index 1 is requester B.
  logic [AW-1:0] reg_mem  [2][DEPTH];
  logic [DW-1:0] data_mem [2][DEPTH];
  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] count    [2];
  logic [AW-1:0] in_reg   [2];
  logic [DW-1:0] in_data  [2];

  logic [1:0]    in_valid;
  logic [1:0]    ready;
  logic [1:0]    not_empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          contested;
  logic          pref_b;
  logic          sel;
  logic [AW-1:0] pop_reg;
  logic [DW-1:0] pop_data;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_reg[0]  = a_reg;
    in_reg[1]  = b_reg;
    in_data[0] = a_data;
    in_data[1] = b_data;
    for (int g = 0; g < 2; g++) begin
      ready[g]     = (count[g] != CW'(DEPTH));
      not_empty[g] = (count[g] != '0);
      push[g]      = in_valid[g] & ready[g];
    end
    contested = &not_empty;
    pop[0]    = not_empty[0] & (~not_empty[1] | ~pref_b);
    pop[1]    = not_empty[1] & (~not_empty[0] |  pref_b);
    sel       = pop[1];
    pop_reg   = reg_mem[sel][rd_ptr[sel]];
    pop_data  = data_mem[sel][rd_ptr[sel]];
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign busy    = (|not_empty) | regWrite;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        wr_ptr[g] <= '0;
        rd_ptr[g] <= '0;
        count[g]  <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (push[g]) wr_ptr[g] <= wr_ptr[g] + PW'(1);
        if (pop[g])  rd_ptr[g] <= rd_ptr[g] + PW'(1);
        count[g] <= count[g] + CW'(push[g]) - CW'(pop[g]);
      end
    end
  end

  // NOTE: storage is deliberately not reset; the counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (push[g]) begin
        reg_mem[g][wr_ptr[g]]  <= in_reg[g];
        data_mem[g][wr_ptr[g]] <= in_data[g];
      end
    end
  end

  // Register-0 entries are still popped and loaded, only the write enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pref_b     <= 1'b0;
    end else begin
      if (|pop) begin
        write_reg  <= pop_reg;
        write_data <= pop_data;
        regWrite   <= (pop_reg != '0);
      end else begin
        regWrite   <= 1'b0;
      end
      if (contested) pref_b <= ~pref_b;
    end
  end

`ifdef WB_FORWARD_EN
  logic [1:0]    hit;
  logic [DW-1:0] hit_data [2];
  logic [PW-1:0] idx;

  // Scan oldest to newest so the last match left standing is the newest entry.
  always_comb begin
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int g = 0; g < 2; g++) begin
      hit[g]      = 1'b0;
      hit_data[g] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr[g] + PW'(k);
        if ((CW'(k) < count[g]) && (reg_mem[g][idx] == fwd_reg)) begin
          hit[g]      = 1'b1;
          hit_data[g] = data_mem[g][idx];
        end
      end
    end
    if (fwd_reg != '0) begin
      if (hit[0]) begin
        fwd_hit  = 1'b1;
        fwd_data = hit_data[0];
      end else if (hit[1]) begin
        fwd_hit  = 1'b1;
        fwd_data = hit_data[1];
      end else if (regWrite && (write_reg == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every issued register-file write.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          regWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          busy;
`ifdef WB_FORWARD_EN
  logic [AW-1:0] fwd_reg;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .regWrite   (regWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy       (busy)
`ifdef WB_FORWARD_EN
    ,
    .fwd_reg    (fwd_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  // Data nibble [31:28] routes a write: B -> exp_b, F -> flushed by reset, anything else -> exp_a.
  wr_t exp_a[$];
  wr_t exp_b[$];
  int  total = 0;
  int  bad   = 0;
  bit  allow_f    = 1'b0;
  bit  saw_b_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit side, input logic [AW-1:0] r, input logic [DW-1:0] d, input bit score);
    bit acc = 1'b0;
    bit rdy;
    if (side) begin b_valid = 1'b1; b_reg = r; b_data = d; end
    else      begin a_valid = 1'b1; a_reg = r; a_data = d; end
    for (int budget = 0; budget < 50 && !acc; budget++) begin
      rdy = side ? b_ready : a_ready;
      if (side && !rdy) saw_b_full = 1'b1;
      if (rdy) begin
        acc = 1'b1;
        if (score) begin
          if (d[31:28] == 4'hB) exp_b.push_back('{r, d});
          else                  exp_a.push_back('{r, d});
        end
      end
      tick();
    end
    if (side) b_valid = 1'b0;
    else      a_valid = 1'b0;
    check(side ? "b_push_accepted" : "a_push_accepted", acc, 1);
  endtask

  // Monitor: compares every write the DUT presents against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && regWrite === 1'b1) begin
        if (write_data[31:28] == 4'hF) begin
          check("flushed_entry_issued", allow_f, 1);
        end else if (write_data[31:28] == 4'hB) begin
          check("sb_b_available", exp_b.size() != 0, 1);
          if (exp_b.size() != 0) begin
            e = exp_b.pop_front();
            check("sb_b_reg", write_reg, e.r);
            check("sb_b_data", write_data, e.d);
          end
        end else begin
          check("sb_a_available", exp_a.size() != 0, 1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            check("sb_a_reg", write_reg, e.r);
            check("sb_a_data", write_data, e.d);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
`ifdef WB_FORWARD_EN
    fwd_reg = '0;
`endif
    tick(); tick();
    check("rst_regWrite", regWrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    reset = 1'b0;
    tick();

    // Single write: accepted at edge N, visible N+1, gone N+2.
    push(1'b0, 5'd5, 32'h0000_00AA, 1'b1);
    check("single_busy_queued", busy, 1);
    check("single_no_write_yet", regWrite, 0);
    tick();
    check("single_regWrite", regWrite, 1);
    check("single_write_reg", write_reg, 5);
    check("single_write_data", write_data, 32'hAA);
    tick();
    check("single_regWrite_drop", regWrite, 0);
    check("single_busy_idle", busy, 0);

    // Contention: A granted first, then the next contested pair grants B first.
    exp_a.push_back('{5'd3, 32'h11});
    exp_a.push_back('{5'd4, 32'h22});
    fork
      push(1'b0, 5'd3, 32'h11, 1'b0);
      push(1'b1, 5'd4, 32'h22, 1'b0);
    join
    tick();
    check("cont1_first_reg", write_reg, 3);
    check("cont1_first_data", write_data, 32'h11);
    tick();
    check("cont1_second_reg", write_reg, 4);
    check("cont1_second_data", write_data, 32'h22);
    tick();
    exp_a.push_back('{5'd7, 32'h44});
    exp_a.push_back('{5'd6, 32'h33});
    fork
      push(1'b0, 5'd6, 32'h33, 1'b0);
      push(1'b1, 5'd7, 32'h44, 1'b0);
    join
    tick();
    check("cont2_first_reg", write_reg, 7);
    check("cont2_first_data", write_data, 32'h44);
    tick();
    check("cont2_second_reg", write_reg, 6);
    check("cont2_second_data", write_data, 32'h33);
    tick();

    // Register 0: popped and loaded, but never written.
    push(1'b0, 5'd0, 32'h0000_DEAD, 1'b0);
    check("r0_busy_queued", busy, 1);
    tick();
    check("r0_regWrite", regWrite, 0);
    check("r0_write_reg", write_reg, 0);
    check("r0_write_data", write_data, 32'hDEAD);
    check("r0_busy_idle", busy, 0);

`ifdef WB_FORWARD_EN
    fwd_reg = 5'd3;
    push(1'b0, 5'd3, 32'h11, 1'b1);
    check("fwd_fifo_hit", fwd_hit, 1);
    check("fwd_fifo_data", fwd_data, 32'h11);
    tick();
    check("fwd_stage_hit", fwd_hit, 1);
    check("fwd_stage_data", fwd_data, 32'h11);
    tick();
    check("fwd_after_commit_hit", fwd_hit, 0);
    check("fwd_after_commit_data", fwd_data, 0);
    fwd_reg = '0;
`endif

    // Backpressure: continuous A traffic against three B entries.
    fork
      begin
        for (int i = 0; i < 6; i++) push(1'b0, AW'(8 + i), 32'hA000_0000 + DW'(i), 1'b1);
      end
      begin
        for (int i = 0; i < 3; i++) push(1'b1, AW'(16 + i), 32'hB000_0000 + DW'(i), 1'b1);
      end
    join
    for (int i = 0; i < 40 && busy; i++) tick();
    check("bp_b_ready_low_seen", saw_b_full, 1);
    check("bp_drain_idle", busy, 0);
    check("bp_exp_a_empty", exp_a.size(), 0);
    check("bp_exp_b_empty", exp_b.size(), 0);

    // Reset mid-operation: queued entries must never issue afterwards.
    allow_f = 1'b1;
    fork
      begin
        push(1'b0, 5'd9,  32'hF000_0001, 1'b0);
        push(1'b0, 5'd10, 32'hF000_0002, 1'b0);
      end
      begin
        push(1'b1, 5'd11, 32'hF000_0003, 1'b0);
        push(1'b1, 5'd12, 32'hF000_0004, 1'b0);
      end
    join
    check("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    tick();
    allow_f = 1'b0;
    check("mid_rst_regWrite", regWrite, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_write_reg", write_reg, 0);
    check("mid_rst_a_ready", a_ready, 1);
    check("mid_rst_b_ready", b_ready, 1);
    reset = 1'b0;
    tick();
    check("mid_post_regWrite", regWrite, 0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_post_busy", busy, 0);

    // After reset the round-robin pointer favours A again.
    exp_a.push_back('{5'd21, 32'h55});
    exp_a.push_back('{5'd22, 32'h66});
    fork
      push(1'b0, 5'd21, 32'h55, 1'b0);
      push(1'b1, 5'd22, 32'h66, 1'b0);
    join
    tick();
    check("post_rst_first_reg", write_reg, 21);
    tick();
    check("post_rst_second_reg", write_reg, 22);
    for (int i = 0; i < 10 && busy; i++) tick();
    tick();
    check("final_idle", busy, 0);
    check("final_exp_a_empty", exp_a.size(), 0);
    check("final_exp_b_empty", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
